// File: rtl/sr_multiplier_nb_if.sv
// Start/operand/result bundle for sr_multiplier_nb.
// master drives btn, signed_mode, a, b; slave returns prod, busy, done.
interface sr_multiplier_nb_if #(
    parameter int N = 5
);
    logic           btn;
    logic           signed_mode;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] prod;
    logic           busy;
    logic           done;

    modport master (
        output btn, signed_mode, a, b,
        input  prod, busy, done
    );

    modport slave (
        input  btn, signed_mode, a, b,
        output prod, busy, done
    );
endinterface

// File: rtl/sr_multiplier_nb.sv
// Sequential shift-and-add N x N multiplier, signed or unsigned, edge-started.
// Ports: clk, rst_n (async low), bus.slave: btn/signed_mode/a/b in, prod/busy/done out.
module sr_multiplier_nb #(
    parameter int N     = 5,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    sr_multiplier_nb_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SIGN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t           state;
    logic             btn_q;
    logic             neg;
    logic [N-1:0]     mag_a;
    logic [CNT_W-1:0] cnt;
    logic [2*N-1:0]   prod_q;
    // Upper N+1 bits: accumulator with carry; lower N bits: remaining multiplier.
    logic [2*N:0]     p;

    logic             start;
    logic [N-1:0]     abs_a;
    logic [N-1:0]     abs_b;
    logic [N:0]       sum;

    assign start = bus.btn & ~btn_q;

    // |-2^(N-1)| wraps to 2^(N-1), which is still correct read as unsigned.
    always_comb begin
        abs_a = bus.a;
        abs_b = bus.b;
        if (bus.signed_mode && bus.a[N-1]) abs_a = ~bus.a + N'(1);
        if (bus.signed_mode && bus.b[N-1]) abs_b = ~bus.b + N'(1);
    end

    assign sum = p[2*N:N] + {1'b0, mag_a};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            btn_q  <= 1'b0;
            neg    <= 1'b0;
            mag_a  <= '0;
            cnt    <= '0;
            prod_q <= '0;
            p      <= '0;
        end else begin
            btn_q <= bus.btn;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        mag_a <= abs_a;
                        p     <= {{(N+1){1'b0}}, abs_b};
                        neg   <= bus.signed_mode & (bus.a[N-1] ^ bus.b[N-1]);
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (p[0]) p <= {1'b0, sum, p[N-1:1]};
                    else      p <= p >> 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= S_SIGN;
                end
                S_SIGN: begin
                    prod_q <= neg ? (~p[2*N-1:0] + (2*N)'(1))
                                  : p[2*N-1:0];
                    state  <= S_DONE;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.prod = prod_q;
    assign bus.busy = (state == S_RUN) || (state == S_SIGN);
    assign bus.done = (state == S_DONE);
endmodule

// File: tb/tb_sr_multiplier_nb.sv
// Directed bench for sr_multiplier_nb at N=5.
// Hand-computed products, latency, busy length, start filtering and reset abort.
module tb_sr_multiplier_nb;
    localparam int N = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    sr_multiplier_nb_if #(.N(N)) bus ();

    sr_multiplier_nb #(.N(N), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse btn for one edge, then wait for done with a bounded loop.
    task automatic run_op(input string tag, input logic sm,
                          input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [2*N-1:0] exp_prod);
        int cycles;
        int busy_cnt;
        bus.signed_mode = sm;
        bus.a = a;
        bus.b = b;
        bus.btn = 1'b1;
        tick();
        bus.btn = 1'b0;
        cycles = 0;
        busy_cnt = 0;
        while (!bus.done && cycles < 20) begin
            if (bus.busy) busy_cnt++;
            tick();
            cycles++;
        end
        chk({tag, "_latency"}, cycles, N + 1);
        chk({tag, "_prod"}, {22'd0, bus.prod}, {22'd0, exp_prod});
        chk({tag, "_busy_len"}, busy_cnt, N + 1);
        tick();
        chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int dones;
        logic [2*N-1:0] seen;

        bus.btn = 1'b0;
        bus.signed_mode = 1'b0;
        bus.a = '0;
        bus.b = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_prod", {22'd0, bus.prod}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_op("u31x31", 1'b0, 5'h1F, 5'h1F, 10'd961);
        run_op("s_min_min", 1'b1, 5'b10000, 5'b10000, 10'd256);
        run_op("s_m3x7", 1'b1, 5'h1D, 5'd7, 10'h3EB);
        run_op("u29x7", 1'b0, 5'h1D, 5'd7, 10'd203);

        // Zero product with btn held high for 20 cycles.
        bus.signed_mode = 1'b0;
        bus.a = 5'd0;
        bus.b = 5'd19;
        bus.btn = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done) dones++;
        end
        bus.btn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.done) dones++;
        end
        chk("hold_dones", dones, 1);
        chk("hold_prod", {22'd0, bus.prod}, 32'd0);

        // Second rising edge during RUN must be ignored.
        bus.a = 5'd3;
        bus.b = 5'd5;
        bus.btn = 1'b1;
        tick();
        bus.btn = 1'b0;
        dones = 0;
        seen = '1;
        for (int i = 0; i < 15; i++) begin
            if (i == 2) begin
                bus.a = 5'd7;
                bus.b = 5'd7;
                bus.btn = 1'b1;
            end
            if (i == 3) bus.btn = 1'b0;
            tick();
            if (bus.done) begin
                dones++;
                seen = bus.prod;
            end
        end
        chk("busy_start_dones", dones, 1);
        chk("busy_start_prod", {22'd0, seen}, 32'd15);

        // Reset during RUN aborts at once.
        bus.a = 5'h1F;
        bus.b = 5'h1F;
        bus.btn = 1'b1;
        tick();
        bus.btn = 1'b0;
        tick();
        chk("pre_abort_busy", {31'd0, bus.busy}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_prod", {22'd0, bus.prod}, 32'd0);
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.done) dones++;
        end
        chk("abort_no_done", dones, 0);

        run_op("u6x5", 1'b0, 5'd6, 5'd5, 10'd30);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
